mem_write_trace_buf: RTL and testbench

//  Synthesizable trace buffer for data-RAM write traffic from NUM_CH CPU lanes.
//  - Captures address, data, lane id and cycle timestamp of each write into an on-chip FIFO.
//  - Sits beside cpu_garage on the RAM write buses. A bench or debug port drains entries

---
 rtl/mem_write_trace_buf.sv | 182 ++++++++++++++++++
 tb/tb_mem_write_trace_buf.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_trace_buf.sv
`default_nettype none
// ============================================================================
// mem_write_trace_buf - per-lane RAM write capture merged round-robin into a
//                       timestamped first-word-fall-through trace FIFO.
// Revision: 1.0
// ============================================================================
module mem_write_trace_buf #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int TS_W   = 32,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Enable,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     filt_en,
  input  logic [ADDR_W-1:0]        filt_lo,
  input  logic [ADDR_W-1:0]        filt_hi,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [CH_W-1:0]          rd_ch,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [LVL_W-1:0]         level,
  output logic [15:0]              drop_cnt
);

  localparam int ENT_W = CH_W + ADDR_W + DATA_W + TS_W;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [NUM_CH-1:0] hold_v_q, hold_v_d;
  logic [ADDR_W-1:0] hold_addr_q [NUM_CH];
  logic [ADDR_W-1:0] hold_addr_d [NUM_CH];
  logic [DATA_W-1:0] hold_data_q [NUM_CH];
  logic [DATA_W-1:0] hold_data_d [NUM_CH];
  logic [TS_W-1:0]   hold_ts_q   [NUM_CH];
  logic [TS_W-1:0]   hold_ts_d   [NUM_CH];
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [ENT_W-1:0]  fifo_mem [DEPTH];

  logic              pop;
  logic              push;
  logic              gnt_found;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W:0]     lane_idx;
  logic [16:0]       drop_sum;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] drain;
  logic [NUM_CH-1:0] drop;
  logic [ENT_W-1:0]  push_entry;
  logic [ENT_W-1:0]  head_entry;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic [ADDR_W-1:0] lane_addr;
    assign lane_addr = ch_addr[i*ADDR_W +: ADDR_W];
    assign hit[i]    = Enable & ch_we[i] &
                       (~filt_en | ((filt_lo <= lane_addr) && (lane_addr <= filt_hi)));
    assign drain[i]  = push && (gnt_idx == CH_W'(i));
    // A drained holding register frees up in time to take this cycle's hit.
    assign drop[i]   = hit[i] & hold_v_q[i] & ~drain[i];
  end

  // Round-robin search starts at the lane after the last one pushed.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    lane_idx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      lane_idx = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (lane_idx >= (CH_W+1)'(NUM_CH)) begin
        lane_idx = lane_idx - (CH_W+1)'(NUM_CH);
      end
      if (!gnt_found && hold_v_q[lane_idx[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = lane_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    rd_valid   = (level_q != '0);
    pop        = rd_valid & rd_ready;
    push       = gnt_found & ((level_q != LVL_W'(DEPTH)) | pop);
    push_entry = {gnt_idx, hold_addr_q[gnt_idx], hold_data_q[gnt_idx], hold_ts_q[gnt_idx]};
  end

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_ts_d   = hold_ts_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit[i] && !drop[i]) begin
        hold_v_d[i]    = 1'b1;
        hold_addr_d[i] = ch_addr[i*ADDR_W +: ADDR_W];
        hold_data_d[i] = ch_data[i*DATA_W +: DATA_W];
        hold_ts_d[i]   = ts_q;
      end else if (drain[i]) begin
        hold_v_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NUM_CH; i++) begin
      drop_sum = drop_sum + 17'(drop[i]);
    end
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ts_q       <= '0;
      hold_v_q   <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_addr_q[i] <= '0;
        hold_data_q[i] <= '0;
        hold_ts_q[i]   <= '0;
      end
    end else begin
      ts_q        <= ts_d;
      hold_v_q    <= hold_v_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      hold_ts_q   <= hold_ts_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

  always_comb begin
    head_entry = fifo_mem[rd_ptr_q];
    rd_ch      = rd_valid ? head_entry[ENT_W-1 -: CH_W]           : '0;
    rd_addr    = rd_valid ? head_entry[TS_W+DATA_W +: ADDR_W]     : '0;
    rd_data    = rd_valid ? head_entry[TS_W +: DATA_W]            : '0;
    rd_ts      = rd_valid ? head_entry[TS_W-1:0]                  : '0;
    level      = level_q;
    drop_cnt   = drop_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_write_trace_buf.sv
`default_nettype none
// ============================================================================
// tb_mem_write_trace_buf - directed + random checks against a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_mem_write_trace_buf;
  localparam int NCH = 2;
  localparam int DEP = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic [1:0]  ch_we = '0;
  logic [31:0] ch_addr = '0;
  logic [31:0] ch_data = '0;
  logic        filt_en = 1'b0;
  logic [15:0] filt_lo = '0;
  logic [15:0] filt_hi = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [0:0]  rd_ch;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic [31:0] rd_ts;
  logic [2:0]  level;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  mem_write_trace_buf #(
    .NUM_CH(NCH), .ADDR_W(16), .DATA_W(16), .DEPTH(DEP), .TS_W(32)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_data(ch_data), .filt_en(filt_en),
    .filt_lo(filt_lo), .filt_hi(filt_hi), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_ts(rd_ts), .level(level), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int          ch;
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] ts;
  } ent_t;

  ent_t        fifo_m[$];
  bit          hv_m[NCH];
  ent_t        hold_m[NCH];
  int          rr_m;
  int          drops_m;
  logic [31:0] ts_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo_m.delete();
    for (int i = 0; i < NCH; i++) hv_m[i] = 1'b0;
    rr_m    = 0;
    drops_m = 0;
    ts_m    = '0;
  endtask

  // One clock of the reference behaviour, using the inputs currently applied.
  task automatic model_step();
    int g;
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      int l;
      l = (rr_m + k) % NCH;
      if (g < 0 && hv_m[l]) g = l;
    end
    if (fifo_m.size() > 0 && rd_ready) void'(fifo_m.pop_front());
    if (g >= 0 && fifo_m.size() < DEP) begin
      fifo_m.push_back(hold_m[g]);
      hv_m[g] = 1'b0;
      rr_m    = (g + 1) % NCH;
    end
    for (int i = 0; i < NCH; i++) begin
      logic [15:0] a;
      bit          h;
      a = ch_addr[i*16 +: 16];
      h = Enable && ch_we[i] && (!filt_en || (a >= filt_lo && a <= filt_hi));
      if (h) begin
        if (hv_m[i]) begin
          if (drops_m < 65535) drops_m++;
        end else begin
          hv_m[i]   = 1'b1;
          hold_m[i] = '{ch: i, addr: a, data: ch_data[i*16 +: 16], ts: ts_m};
        end
      end
    end
    ts_m = ts_m + 32'd1;
  endtask

  task automatic compare();
    chk("rd_valid", rd_valid, fifo_m.size() != 0);
    chk("level", level, fifo_m.size());
    chk("drop_cnt", drop_cnt, drops_m);
    if (fifo_m.size() != 0) begin
      chk("rd_ch", rd_ch, fifo_m[0].ch);
      chk("rd_addr", rd_addr, fifo_m[0].addr);
      chk("rd_data", rd_data, fifo_m[0].data);
      chk("rd_ts", rd_ts, fifo_m[0].ts);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge Clk);
    @(negedge Clk);
    compare();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev0;
    logic [15:0] faddr [4];

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_ts", rd_ts, 0);
    Reset = 1'b0;
    Enable = 1'b1;
    model_reset();

    // Single write at ts=7
    repeat (7) step();
    ch_we = 2'b01; ch_addr[15:0] = 16'h0010; ch_data[15:0] = 16'h1234;
    step();
    ch_we = 2'b00;
    chk("single_held_not_visible", rd_valid, 0);
    step();
    chk("single_valid", rd_valid, 1);
    chk("single_ch", rd_ch, 0);
    chk("single_addr", rd_addr, 16'h0010);
    chk("single_data", rd_data, 16'h1234);
    chk("single_ts", rd_ts, 32'd7);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("single_popped", level, 0);

    // Collision at ts=20; lane 0 was granted last, so lane 1 goes first
    for (int n = 0; n < 40 && ts_m != 32'd20; n++) step();
    ch_we = 2'b11; ch_addr = {16'h0200, 16'h0100}; ch_data = {16'hBBBB, 16'hAAAA};
    step();
    ch_we = 2'b00;
    step();
    chk("coll_first_ch", rd_ch, 1);
    chk("coll_first_ts", rd_ts, 32'd20);
    chk("coll_first_addr", rd_addr, 16'h0200);
    step();
    chk("coll_level", level, 2);
    rd_ready = 1'b1;
    step();
    chk("coll_second_ch", rd_ch, 0);
    chk("coll_second_ts", rd_ts, 32'd20);
    step();
    rd_ready = 1'b0;
    chk("coll_empty", level, 0);
    chk("coll_no_drop", drop_cnt, 0);

    // Overflow: 12 back-to-back lane-0 writes, nothing drained
    for (int w = 0; w < 12; w++) begin
      ch_we = 2'b01; ch_addr[15:0] = 16'h0300 + 16'(w); ch_data[15:0] = 16'(w);
      step();
    end
    ch_we = 2'b00;
    chk("ovf_level", level, 4);
    chk("ovf_drop", drop_cnt, 7);
    chk("ovf_head", rd_addr, 16'h0300);

    // Full FIFO with pop: lane 1 pushes on the same edge as the pop
    ch_we = 2'b10; ch_addr[31:16] = 16'h0400; ch_data[31:16] = 16'h5555;
    step();
    ch_we = 2'b00;
    rd_ready = 1'b1;
    step();
    chk("fullpop_level", level, 4);
    chk("fullpop_drop", drop_cnt, 7);
    chk("fullpop_head", rd_addr, 16'h0301);
    prev0 = '0;
    for (int n = 0; n < 20 && level != 0; n++) begin
      if (rd_ch == 1'b0) begin
        chk("lane0_ts_increasing", rd_ts > prev0, 1);
        prev0 = rd_ts;
      end
      step();
    end
    rd_ready = 1'b0;
    chk("drained", level, 0);

    // Address filter
    filt_en = 1'b1; filt_lo = 16'h0100; filt_hi = 16'h01FF;
    faddr = '{16'h00FF, 16'h0100, 16'h01FF, 16'h0200};
    for (int n = 0; n < 4; n++) begin
      ch_we = 2'b01; ch_addr[15:0] = faddr[n]; ch_data[15:0] = 16'hF000 + 16'(n);
      step();
    end
    ch_we = 2'b00;
    step(); step();
    chk("filt_level", level, 2);
    chk("filt_first", rd_addr, 16'h0100);
    rd_ready = 1'b1;
    step();
    chk("filt_second", rd_addr, 16'h01FF);
    step();
    rd_ready = 1'b0;
    filt_lo = 16'h0200; filt_hi = 16'h0100;
    ch_we = 2'b11; ch_addr = {16'h0180, 16'h0150};
    step();
    ch_we = 2'b00;
    step();
    chk("filt_inverted_none", level, 0);
    chk("filt_inverted_nodrop", drop_cnt, 7);
    filt_en = 1'b0;

    // Reset mid-stream
    for (int n = 0; n < 6; n++) begin
      ch_we = 2'b11; ch_addr = {16'h0700 + 16'(n), 16'h0600 + 16'(n)};
      step();
    end
    ch_we = 2'b00;
    chk("prereset_level", level, 4);
    Reset = 1'b1;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_drop", drop_cnt, 0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    ch_we = 2'b10; ch_addr[31:16] = 16'h0777; ch_data[31:16] = 16'h0042;
    step();
    ch_we = 2'b00;
    step();
    chk("post_rst_ts", rd_ts, 32'd0);
    chk("post_rst_ch", rd_ch, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      Enable   = ($urandom_range(0, 9) != 0);
      ch_we    = 2'($urandom_range(0, 3));
      ch_addr  = {16'($urandom_range(0, 15)), 16'($urandom_range(0, 15))};
      ch_data  = $urandom;
      filt_en  = ($urandom_range(0, 3) == 0);
      filt_lo  = 16'($urandom_range(0, 15));
      filt_hi  = 16'($urandom_range(0, 15));
      rd_ready = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                      : ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
